// File: rtl/regf_wb_arbiter.sv
// Two-requester writeback arbiter in front of a register file.
// Each requester has a one-entry holding buffer; grants alternate when both are full.
module regf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        wr,
  output logic [4:0]  Ad_rd,
  output logic [31:0] rd_data_in,
  output logic        pend,
  output logic [15:0] wb_count
);

  logic        r_a_full;
  logic [4:0]  r_a_rd;
  logic [31:0] r_a_data;
  logic        r_b_full;
  logic [4:0]  r_b_rd;
  logic [31:0] r_b_data;
  logic        r_last_gnt_b;
  logic        r_wr;
  logic [4:0]  r_ad_rd;
  logic [31:0] r_wr_data;
  logic [15:0] r_wb_count;

  logic        w_gnt_a;
  logic        w_gnt_b;
  logic        w_any_gnt;
  logic [4:0]  w_sel_rd;
  logic [31:0] w_sel_data;
  logic        w_commit;
  logic        w_a_take;
  logic        w_b_take;

  // Arbitration looks only at buffered entries, so grant never depends on this cycle's valids.
  assign w_gnt_a    = r_a_full && (!r_b_full || r_last_gnt_b);
  assign w_gnt_b    = r_b_full && (!r_a_full || !r_last_gnt_b);
  assign w_any_gnt  = w_gnt_a || w_gnt_b;
  assign w_sel_rd   = w_gnt_a ? r_a_rd   : r_b_rd;
  assign w_sel_data = w_gnt_a ? r_a_data : r_b_data;
  assign w_commit   = w_any_gnt && (w_sel_rd != 5'd0);

  assign a_ready  = rst && (!r_a_full || w_gnt_a);
  assign b_ready  = rst && (!r_b_full || w_gnt_b);
  assign w_a_take = a_valid && a_ready;
  assign w_b_take = b_valid && b_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a_full <= 1'b0;
      r_a_rd   <= 5'd0;
      r_a_data <= 32'd0;
    end else if (w_a_take) begin
      r_a_full <= 1'b1;
      r_a_rd   <= a_rd;
      r_a_data <= a_data;
    end else if (w_gnt_a) begin
      r_a_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_b_full <= 1'b0;
      r_b_rd   <= 5'd0;
      r_b_data <= 32'd0;
    end else if (w_b_take) begin
      r_b_full <= 1'b1;
      r_b_rd   <= b_rd;
      r_b_data <= b_data;
    end else if (w_gnt_b) begin
      r_b_full <= 1'b0;
    end
  end

  // Resetting last grant to B lets A win the first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_gnt_b <= 1'b1;
      r_wr         <= 1'b0;
      r_ad_rd      <= 5'd0;
      r_wr_data    <= 32'd0;
      r_wb_count   <= 16'd0;
    end else begin
      r_wr <= w_commit;
      if (w_any_gnt) begin
        r_last_gnt_b <= w_gnt_b;
        r_ad_rd      <= w_sel_rd;
        r_wr_data    <= w_sel_data;
      end
      if (w_commit) begin
        r_wb_count <= r_wb_count + 16'd1;
      end
    end
  end

  assign wr         = r_wr;
  assign Ad_rd      = r_ad_rd;
  assign rd_data_in = r_wr_data;
  assign pend       = r_a_full || r_b_full;
  assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Bench for regf_wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_regf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = 5'd0;
  logic [31:0] a_data = 32'd0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = 5'd0;
  logic [31:0] b_data = 32'd0;
  logic        b_ready;
  logic        wr;
  logic [4:0]  Ad_rd;
  logic [31:0] rd_data_in;
  logic        pend;
  logic [15:0] wb_count;

  regf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .wr(wr), .Ad_rd(Ad_rd), .rd_data_in(rd_data_in), .pend(pend), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each requester's accepted-but-unwritten entries as a queue.
  logic [36:0] qa[$];
  logic [36:0] qb[$];
  bit          m_last_b = 1'b1;
  logic        m_wr = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic [15:0] m_cnt = 16'd0;
  bit          m_acc_a = 1'b0;
  bit          m_acc_b = 1'b0;

  function automatic bit m_ga();
    return (qa.size() != 0) && ((qb.size() == 0) || m_last_b);
  endfunction

  function automatic bit m_gb();
    return (qb.size() != 0) && ((qa.size() == 0) || !m_last_b);
  endfunction

  task automatic model_edge();
    bit ga, gb;
    logic [36:0] e;
    if (!rst) begin
      qa.delete();
      qb.delete();
      m_last_b = 1'b1;
      m_wr = 1'b0;
      m_rd = 5'd0;
      m_data = 32'd0;
      m_cnt = 16'd0;
      m_acc_a = 1'b0;
      m_acc_b = 1'b0;
    end else begin
      ga = m_ga();
      gb = m_gb();
      m_acc_a = a_valid && ((qa.size() == 0) || ga);
      m_acc_b = b_valid && ((qb.size() == 0) || gb);
      e = '0;
      if (ga) begin
        e = qa.pop_front();
        m_last_b = 1'b0;
      end else if (gb) begin
        e = qb.pop_front();
        m_last_b = 1'b1;
      end
      if (ga || gb) begin
        m_rd = e[36:32];
        m_data = e[31:0];
        m_wr = (m_rd != 5'd0);
        if (m_wr) m_cnt = m_cnt + 16'd1;
      end else begin
        m_wr = 1'b0;
      end
      if (m_acc_a) qa.push_back({a_rd, a_data});
      if (m_acc_b) qb.push_back({b_rd, b_data});
    end
  endtask

  bit chk_en = 1'b0;
  bit log_en = 1'b0;
  logic [36:0] wlog[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_ready", {31'd0, a_ready}, {31'd0, rst && ((qa.size() == 0) || m_ga())});
      check("b_ready", {31'd0, b_ready}, {31'd0, rst && ((qb.size() == 0) || m_gb())});
      check("wr", {31'd0, wr}, {31'd0, m_wr});
      check("Ad_rd", {27'd0, Ad_rd}, {27'd0, m_rd});
      check("rd_data_in", rd_data_in, m_data);
      check("pend", {31'd0, pend}, {31'd0, (qa.size() != 0) || (qb.size() != 0)});
      check("wb_count", {16'd0, wb_count}, {16'd0, m_cnt});
      if (log_en && wr) wlog.push_back({Ad_rd, rd_data_in});
    end
  end

  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    rst = r;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] ad, bd;

    // Reset state
    do_reset();
    chk_en = 1'b1;
    do_reset();
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_pend", {31'd0, pend}, 32'd0);
    check("rst_count", {16'd0, wb_count}, 32'd0);
    check("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_Ad_rd", {27'd0, Ad_rd}, 32'd0);

    // Single A write: two edges to commit
    step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    check("a1_wr_early", {31'd0, wr}, 32'd0);
    idle(1);
    check("a1_wr", {31'd0, wr}, 32'd1);
    check("a1_rd", {27'd0, Ad_rd}, 32'd5);
    check("a1_data", rd_data_in, 32'h1234);
    check("a1_count", {16'd0, wb_count}, 32'd1);
    idle(1);
    check("a1_wr_off", {31'd0, wr}, 32'd0);
    check("a1_rd_hold", {27'd0, Ad_rd}, 32'd5);

    // Contention after reset: writes alternate A,B,A,B
    do_reset();
    wlog.delete();
    log_en = 1'b1;
    ad = 32'hAA;
    bd = 32'hBB;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 5'd3, ad, 1'b1, 5'd4, bd);
      if (i == 0) begin
        check("cont_a_ready_first", {31'd0, a_ready}, 32'd1);
        check("cont_b_ready_first", {31'd0, b_ready}, 32'd0);
      end
      if (m_acc_a) ad = ad + 32'd1;
      if (m_acc_b) bd = bd + 32'd1;
    end
    idle(4);
    log_en = 1'b0;
    check("cont_nwrites", wlog.size(), 32'd5);
    if (wlog.size() >= 4) begin
      check("cont_w0", {27'd0, wlog[0][36:32]} ^ wlog[0][31:0], 32'h3 ^ 32'hAA);
      check("cont_w1", {27'd0, wlog[1][36:32]} ^ wlog[1][31:0], 32'h4 ^ 32'hBB);
      check("cont_w2", {27'd0, wlog[2][36:32]} ^ wlog[2][31:0], 32'h3 ^ 32'hAB);
      check("cont_w3", {27'd0, wlog[3][36:32]} ^ wlog[3][31:0], 32'h4 ^ 32'hBC);
    end

    // x0 write is drained but not committed
    do_reset();
    step(1'b1, 1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 32'd0);
    check("x0_b_ready", {31'd0, b_ready}, 32'd1);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    idle(1);
    check("x0_wr", {31'd0, wr}, 32'd0);
    check("x0_pend", {31'd0, pend}, 32'd0);
    idle(1);
    check("x0_count", {16'd0, wb_count}, 32'd1);

    // Same destination in both buffers: written in grant order
    do_reset();
    wlog.delete();
    log_en = 1'b1;
    step(1'b1, 1'b1, 5'd7, 32'h111, 1'b1, 5'd7, 32'h222);
    idle(3);
    log_en = 1'b0;
    check("order_n", wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      check("order_0", wlog[0][31:0], 32'h111);
      check("order_1", wlog[1][31:0], 32'h222);
    end

    // Streaming A only: ready held high, one write per cycle
    do_reset();
    wlog.delete();
    log_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 5'(i + 1), 32'(i * 16), 1'b0, 5'd0, 32'd0);
      check("stream_a_ready", {31'd0, a_ready}, 32'd1);
    end
    idle(2);
    log_en = 1'b0;
    check("stream_n", wlog.size(), 32'd8);
    check("stream_count", {16'd0, wb_count}, 32'd8);

    // Mid-stream reset discards both full buffers
    do_reset();
    step(1'b1, 1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2);
    check("mid_pend_before", {31'd0, pend}, 32'd1);
    step(1'b0, 1'b1, 5'd11, 32'h3, 1'b1, 5'd12, 32'h4);
    check("mid_pend", {31'd0, pend}, 32'd0);
    check("mid_wr", {31'd0, wr}, 32'd0);
    check("mid_count", {16'd0, wb_count}, 32'd0);
    check("mid_a_ready", {31'd0, a_ready}, 32'd0);
    step(1'b1, 1'b1, 5'd13, 32'h5, 1'b1, 5'd14, 32'h6);
    idle(1);
    check("mid_first_rd", {27'd0, Ad_rd}, 32'd13);
    idle(1);
    check("mid_second_rd", {27'd0, Ad_rd}, 32'd14);

    // Counter wrap after 65535 commits
    do_reset();
    for (int i = 0; i < 65535; i++) step(1'b1, 1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 32'd0);
    idle(1);
    check("wrap_full", {16'd0, wb_count}, 32'hFFFF);
    step(1'b1, 1'b1, 5'd1, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    idle(1);
    check("wrap_wr", {31'd0, wr}, 32'd1);
    check("wrap_zero", {16'd0, wb_count}, 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
